// File: rtl/delta_pkg.sv
// Shared defaults and mode encodings for the delta detector bank.
package delta_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_NUM_CH  = 4;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_THR_RST = 2;

    // mode input encoding
    localparam logic MODE_TRACK = 1'b0;   // event moves the baseline to the new sample
    localparam logic MODE_HOLD  = 1'b1;   // event leaves the baseline where it was

endpackage

// File: rtl/delta_detect_bank_if.sv
// Sample/result bus of the delta detector bank.
//
// Handshake: in_valid is a one-cycle strobe qualifying in_ch/in_data/rebase.
// There is no ready; the bank accepts one sample every cycle and never stalls.
// out_valid is a one-cycle strobe qualifying out_event/out_ch/out_delta, which
// keep their last values while out_valid is low. thr_we, clr_cnt and mode are
// level controls sampled at the clock edge; rd_ch/rd_cnt is a combinational
// read port.
interface delta_detect_bank_if
    import delta_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W  = DEF_CNT_W
) ();

    localparam int CH_W = $clog2(NUM_CH);

    logic              in_valid;
    logic [CH_W-1:0]   in_ch;
    logic [DATA_W-1:0] in_data;
    logic              mode;
    logic              thr_we;
    logic [DATA_W-1:0] thr_data;
    logic              rebase;
    logic              clr_cnt;
    logic [CH_W-1:0]   rd_ch;
    logic [CNT_W-1:0]  rd_cnt;
    logic              out_valid;
    logic              out_event;
    logic [CH_W-1:0]   out_ch;
    logic [DATA_W-1:0] out_delta;

    modport master (
        output in_valid, in_ch, in_data, mode, thr_we, thr_data, rebase,
               clr_cnt, rd_ch,
        input  rd_cnt, out_valid, out_event, out_ch, out_delta
    );

    modport slave (
        input  in_valid, in_ch, in_data, mode, thr_we, thr_data, rebase,
               clr_cnt, rd_ch,
        output rd_cnt, out_valid, out_event, out_ch, out_delta
    );

endinterface

// File: rtl/delta_absdiff.sv
// Unsigned absolute difference, larger operand minus smaller, so it never wraps.
module delta_absdiff #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] diff
);

    // pick the subtraction order that stays non-negative
    always_comb begin
        diff = (a >= b) ? (a - b) : (b - a);
    end

endmodule

// File: rtl/delta_detect_bank.sv
// Multi-channel change detector. Stage 1 looks up the channel baseline and
// computes |sample - baseline|; stage 2 compares against the threshold,
// updates baseline/init/counter state and drives the result strobe.
module delta_detect_bank
    import delta_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int THR_RST = DEF_THR_RST
) (
    input  logic                clk,
    input  logic                rst_n,   // asynchronous, asserted high
    delta_detect_bank_if.slave  bus
);

    localparam int               CH_W    = $clog2(NUM_CH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // per-channel state and threshold
    logic [DATA_W-1:0] base_q [NUM_CH];
    logic [NUM_CH-1:0] init_q;
    logic [CNT_W-1:0]  cnt_q  [NUM_CH];
    logic [DATA_W-1:0] thr_q;

    // stage 1 registers
    logic              s1_valid;
    logic [CH_W-1:0]   s1_ch;
    logic [DATA_W-1:0] s1_data;
    logic              s1_rebase;
    logic              s1_init;
    logic [DATA_W-1:0] s1_delta;

    // result registers
    logic              out_valid_q;
    logic              out_event_q;
    logic [CH_W-1:0]   out_ch_q;
    logic [DATA_W-1:0] out_delta_q;

    // stage 0 lookup and stage 2 decision
    logic              fwd_hit;
    logic [DATA_W-1:0] s0_base;
    logic              s0_init;
    logic [DATA_W-1:0] s0_delta;
    logic              s2_load;
    logic              s2_event;
    logic              s2_wr;

    // stage 2 decision: baseline load, threshold event, and whether the baseline is rewritten
    always_comb begin
        s2_load  = s1_valid && (!s1_init || s1_rebase);
        s2_event = s1_valid && s1_init && !s1_rebase && (s1_delta > thr_q);
        s2_wr    = s2_load || (s2_event && (bus.mode == MODE_TRACK));
    end

    // baseline lookup, taking the value stage 2 is writing this cycle for the same channel
    always_comb begin
        fwd_hit = s2_wr && (s1_ch == bus.in_ch);
        s0_base = fwd_hit ? s1_data : base_q[bus.in_ch];
        s0_init = fwd_hit ? 1'b1    : init_q[bus.in_ch];
    end

    delta_absdiff #(.DATA_W(DATA_W)) u_absdiff (
        .a    (bus.in_data),
        .b    (s0_base),
        .diff (s0_delta)
    );

    // stage 1 capture; valid bit cleared by reset so in-flight samples are dropped
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            s1_valid  <= 1'b0;
            s1_ch     <= '0;
            s1_data   <= '0;
            s1_rebase <= 1'b0;
            s1_init   <= 1'b0;
            s1_delta  <= '0;
        end else begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_ch     <= bus.in_ch;
                s1_data   <= bus.in_data;
                s1_rebase <= bus.rebase;
                s1_init   <= s0_init;
                s1_delta  <= s0_delta;
            end
        end
    end

    // baseline and init flag update from stage 2
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                base_q[i] <= '0;
            end
            init_q <= '0;
        end else if (s2_wr) begin
            base_q[s1_ch] <= s1_data;
            init_q[s1_ch] <= 1'b1;
        end
    end

    // saturating event counters; a clear in the same cycle as an event wins
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (bus.clr_cnt) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (s2_event && (cnt_q[s1_ch] != CNT_MAX)) begin
            cnt_q[s1_ch] <= cnt_q[s1_ch] + 1'b1;
        end
    end

    // threshold register; a write takes effect for decisions from the next cycle on
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            thr_q <= DATA_W'(THR_RST);
        end else if (bus.thr_we) begin
            thr_q <= bus.thr_data;
        end
    end

    // result registers; payload holds its value between strobes
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            out_valid_q <= 1'b0;
            out_event_q <= 1'b0;
            out_ch_q    <= '0;
            out_delta_q <= '0;
        end else begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                out_event_q <= s2_event;
                out_ch_q    <= s1_ch;
                out_delta_q <= s2_load ? '0 : s1_delta;
            end
        end
    end

    assign bus.rd_cnt    = cnt_q[bus.rd_ch];
    assign bus.out_valid = out_valid_q;
    assign bus.out_event = out_event_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_delta = out_delta_q;

endmodule

// File: tb/tb_delta_detect_bank.sv
// Directed bench for delta_detect_bank (DATA_W=8, NUM_CH=4, CNT_W=2, THR_RST=2).
module tb_delta_detect_bank;

    import delta_pkg::*;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    delta_detect_bank_if #(.DATA_W(8), .NUM_CH(4), .CNT_W(2)) bus ();

    delta_detect_bank #(
        .DATA_W  (8),
        .NUM_CH  (4),
        .CNT_W   (2),
        .THR_RST (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, required finish before 200000");
        $fatal(1, "time limit");
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.rebase   = 1'b0;
    endtask

    task automatic send(input logic [1:0] ch, input logic [7:0] data, input logic rb);
        bus.in_valid = 1'b1;
        bus.in_ch    = ch;
        bus.in_data  = data;
        bus.rebase   = rb;
        tick();
        idle();
    endtask

    task automatic write_thr(input logic [7:0] val);
        bus.thr_we   = 1'b1;
        bus.thr_data = val;
        tick();
        bus.thr_we   = 1'b0;
    endtask

    // checkers
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_res(input string tag, input logic [1:0] ch, input logic ev, input logic [7:0] dl);
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, ".event"}, 32'(bus.out_event), 32'(ev));
        chk({tag, ".ch"},    32'(bus.out_ch),    32'(ch));
        chk({tag, ".delta"}, 32'(bus.out_delta), 32'(dl));
    endtask

    task automatic chk_cnt(input string tag, input logic [1:0] ch, input logic [1:0] exp);
        bus.rd_ch = ch;
        #1;
        chk(tag, 32'(bus.rd_cnt), 32'(exp));
    endtask

    // directed sequence
    initial begin
        n_tests      = 0;
        n_fail       = 0;
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_ch    = '0;
        bus.in_data  = '0;
        bus.mode     = MODE_TRACK;
        bus.thr_we   = 1'b0;
        bus.thr_data = '0;
        bus.rebase   = 1'b0;
        bus.clr_cnt  = 1'b0;
        bus.rd_ch    = '0;

        // reset values
        repeat (3) tick();
        chk("rst.valid", 32'(bus.out_valid), 32'd0);
        chk("rst.event", 32'(bus.out_event), 32'd0);
        chk("rst.ch",    32'(bus.out_ch),    32'd0);
        chk("rst.delta", 32'(bus.out_delta), 32'd0);
        chk_cnt("rst.cnt0", 2'd0, 2'd0);
        rst_n = 1'b0;
        tick();

        // track mode, ch0: 10 12 13 20 back-to-back
        send(2'd0, 8'd10, 1'b0);
        chk("t1.lat", 32'(bus.out_valid), 32'd0);
        send(2'd0, 8'd12, 1'b0);
        chk_res("t1.s10", 2'd0, 1'b0, 8'd0);
        send(2'd0, 8'd13, 1'b0);
        chk_res("t1.s12", 2'd0, 1'b0, 8'd2);
        send(2'd0, 8'd20, 1'b0);
        chk_res("t1.s13", 2'd0, 1'b1, 8'd3);
        tick();
        chk_res("t1.s20", 2'd0, 1'b1, 8'd7);
        tick();
        chk("t1.drop",      32'(bus.out_valid), 32'd0);
        chk("t1.hold_ev",   32'(bus.out_event), 32'd1);
        chk("t1.hold_dl",   32'(bus.out_delta), 32'd7);
        chk_cnt("t1.cnt0", 2'd0, 2'd2);

        // hold mode, ch1: 50 60 61, then 52 shows baseline still 50
        bus.mode = MODE_HOLD;
        send(2'd1, 8'd50, 1'b0);
        send(2'd1, 8'd60, 1'b0);
        chk_res("t2.s50", 2'd1, 1'b0, 8'd0);
        send(2'd1, 8'd61, 1'b0);
        chk_res("t2.s60", 2'd1, 1'b1, 8'd10);
        tick();
        chk_res("t2.s61", 2'd1, 1'b1, 8'd11);
        send(2'd1, 8'd52, 1'b0);
        tick();
        chk_res("t2.s52", 2'd1, 1'b0, 8'd2);
        chk_cnt("t2.cnt1", 2'd1, 2'd2);
        bus.mode = MODE_TRACK;

        // threshold 0 then 200, ch2
        write_thr(8'd0);
        send(2'd2, 8'd5, 1'b0);
        send(2'd2, 8'd6, 1'b0);
        chk_res("t3.s5", 2'd2, 1'b0, 8'd0);
        send(2'd2, 8'd6, 1'b0);
        chk_res("t3.s6a", 2'd2, 1'b1, 8'd1);
        tick();
        chk_res("t3.s6b", 2'd2, 1'b0, 8'd0);
        write_thr(8'd200);
        send(2'd2, 8'd255, 1'b0);
        send(2'd2, 8'd0, 1'b0);
        chk_res("t3.s255", 2'd2, 1'b1, 8'd249);
        tick();
        chk_res("t3.s0", 2'd2, 1'b1, 8'd255);
        chk_cnt("t3.cnt2", 2'd2, 2'd3);

        // rebase on ch1 (baseline 50, counter 2)
        write_thr(8'd2);
        send(2'd1, 8'd200, 1'b1);
        tick();
        chk_res("t5.rebase", 2'd1, 1'b0, 8'd0);
        send(2'd1, 8'd201, 1'b0);
        tick();
        chk_res("t5.after", 2'd1, 1'b0, 8'd1);
        chk_cnt("t5.cnt1", 2'd1, 2'd2);

        // ch3 saturation with CNT_W=2, then clear coincident with 6th event
        send(2'd3, 8'd0, 1'b0);
        send(2'd3, 8'd10, 1'b0);
        chk_res("t4.load", 2'd3, 1'b0, 8'd0);
        send(2'd3, 8'd20, 1'b0);
        chk_res("t4.e1", 2'd3, 1'b1, 8'd10);
        send(2'd3, 8'd30, 1'b0);
        send(2'd3, 8'd40, 1'b0);
        send(2'd3, 8'd50, 1'b0);
        tick();
        chk_res("t4.e5", 2'd3, 1'b1, 8'd10);
        chk_cnt("t4.sat", 2'd3, 2'd3);
        send(2'd3, 8'd60, 1'b0);
        bus.clr_cnt = 1'b1;
        tick();
        bus.clr_cnt = 1'b0;
        chk_res("t4.e6", 2'd3, 1'b1, 8'd10);
        chk_cnt("t4.clr3", 2'd3, 2'd0);
        chk_cnt("t4.clr0", 2'd0, 2'd0);
        chk_cnt("t4.clr1", 2'd1, 2'd0);

        // one counted event on ch2 (baseline 0), then raise thr before reset
        send(2'd2, 8'd50, 1'b0);
        tick();
        chk_res("t6.ev", 2'd2, 1'b1, 8'd50);
        chk_cnt("t6.cnt2", 2'd2, 2'd1);
        write_thr(8'd100);

        // reset pulsed with samples in flight
        send(2'd0, 8'd100, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_ch    = 2'd0;
        bus.in_data  = 8'd101;
        rst_n        = 1'b1;
        tick();
        idle();
        chk("t7.rst_v1", 32'(bus.out_valid), 32'd0);
        tick();
        chk("t7.rst_v2", 32'(bus.out_valid), 32'd0);
        rst_n = 1'b0;
        tick();
        chk("t7.post_v1", 32'(bus.out_valid), 32'd0);
        tick();
        chk("t7.post_v2", 32'(bus.out_valid), 32'd0);
        for (int c = 0; c < 4; c++) begin
            chk_cnt($sformatf("t7.cnt%0d", c), 2'(c), 2'd0);
        end

        // post-reset: ch0 uninitialised again, thr back to 2
        send(2'd0, 8'd7, 1'b0);
        chk("t7.lat", 32'(bus.out_valid), 32'd0);
        send(2'd0, 8'd9, 1'b0);
        chk_res("t7.s7", 2'd0, 1'b0, 8'd0);
        send(2'd0, 8'd10, 1'b0);
        chk_res("t7.s9", 2'd0, 1'b0, 8'd2);
        tick();
        chk_res("t7.s10", 2'd0, 1'b1, 8'd3);
        chk_cnt("t7.cnt0", 2'd0, 2'd1);

        // final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
